router_fsm_ctrl: RTL and testbench

Input-side sequencing FSM for the 1x3 router. It decodes the header address, waits for the destination FIFO to drain, and steps the register datapath through header, payload, full-stall and parity phases. It drives the datapath's phase strobes, FIFO write enable and busy back-pressure, and aborts a packet on its port's soft reset.

---
 rtl/router_fsm_ctrl.sv | 75 +++++++
 tb/tb_router_fsm_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl: router input sequencing FSM driving datapath phase strobes, FIFO write enable and busy
module router_fsm_ctrl #(
  parameter logic [1:0] INVALID_ADDR = 2'b11
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);
  localparam logic [2:0] S_DA  = 3'd0;
  localparam logic [2:0] S_WTE = 3'd1;
  localparam logic [2:0] S_LFD = 3'd2;
  localparam logic [2:0] S_LD  = 3'd3;
  localparam logic [2:0] S_FF  = 3'd4;
  localparam logic [2:0] S_LAF = 3'd5;
  localparam logic [2:0] S_LP  = 3'd6;
  localparam logic [2:0] S_CPE = 3'd7;
  logic [2:0] state_q, state_d;
  logic [1:0] addr_q, addr_d, a;
  logic       empty_a, srst_a, hdr_ok;
  always_comb begin
    hdr_ok  = pkt_valid && data_in != INVALID_ADDR;
    a       = state_q == S_DA ? data_in : addr_q;
    empty_a = a == 2'd0 ? fifo_empty_0 : a == 2'd1 ? fifo_empty_1 : a == 2'd2 ? fifo_empty_2 : 1'b0;
    srst_a  = addr_q == 2'd0 ? soft_reset_0 : addr_q == 2'd1 ? soft_reset_1 : addr_q == 2'd2 ? soft_reset_2 : 1'b0;
    addr_d  = state_q == S_DA && hdr_ok ? data_in : addr_q;
    state_d = S_DA;
    case (state_q)
      S_DA:    state_d = hdr_ok ? (empty_a ? S_LFD : S_WTE) : S_DA;
      S_WTE:   state_d = empty_a ? S_LFD : S_WTE;
      S_LFD:   state_d = S_LD;
      S_LD:    state_d = fifo_full ? S_FF : !pkt_valid ? S_LP : S_LD;
      S_FF:    state_d = fifo_full ? S_FF : S_LAF;
      S_LAF:   state_d = parity_done ? S_DA : low_pkt_valid ? S_LP : S_LD;
      S_LP:    state_d = S_CPE;
      S_CPE:   state_d = fifo_full ? S_FF : S_DA;
      default: state_d = S_DA;
    endcase
    if (state_q != S_DA && srst_a) state_d = S_DA;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  assign detect_add    = state_q == S_DA;
  assign lfd_state     = state_q == S_LFD;
  assign ld_state      = state_q == S_LD;
  assign laf_state     = state_q == S_LAF;
  assign full_state    = state_q == S_FF;
  assign rst_int_reg   = state_q == S_CPE;
  assign write_enb_reg = lfd_state || ld_state || laf_state || state_q == S_LP;
  assign busy          = !(detect_add || ld_state);
endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb_router_fsm_ctrl: vector table, corner sequences and randomized model check of router_fsm_ctrl
module tb_router_fsm_ctrl;
  logic clock = 0, resetn = 0;
  logic pkt_valid = 0, fifo_full = 0, parity_done = 0, low_pkt_valid = 0;
  logic [1:0] data_in = 0;
  logic [2:0] emp = 3'b111, srst = 3'b000;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy;
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
  router_fsm_ctrl dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );
  wire [7:0] outs = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_WTE = 8'b0000_0001;
  localparam logic [7:0] O_LFD = 8'b0100_0101;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_FF  = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  typedef struct {
    logic pv; logic [1:0] din; logic full; logic [2:0] emp; logic [2:0] srst; logic pd; logic lpv;
    logic [7:0] exp; string name;
  } vec_t;
  vec_t vecs[$];
  typedef enum {M_IDLE, M_WAIT, M_HDR, M_BODY, M_STALL, M_RESUME, M_PAR, M_CHK} mst_t;
  mst_t ms;
  logic [1:0] maddr;
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask
  task automatic add(input string name, input logic pv, input logic [1:0] din, input logic full,
                     input logic [2:0] e, input logic [2:0] s, input logic pd, input logic lpv,
                     input logic [7:0] exp);
    vec_t v;
    v.name = name; v.pv = pv; v.din = din; v.full = full; v.emp = e; v.srst = s;
    v.pd = pd; v.lpv = lpv; v.exp = exp;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic pv, input logic [1:0] din, input logic full, input logic [2:0] e,
                       input logic [2:0] s, input logic pd, input logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = full; emp = e; srst = s; parity_done = pd; low_pkt_valid = lpv;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [7:0] model_out(input mst_t s);
    logic loading = s inside {M_HDR, M_BODY, M_PAR, M_RESUME};
    logic free = s inside {M_IDLE, M_BODY};
    return {s == M_IDLE, s == M_HDR, s == M_BODY, s == M_RESUME, s == M_STALL, loading, s == M_CHK, !free};
  endfunction
  function automatic mst_t model_next(input mst_t s, input logic [1:0] addr);
    int dest = (s == M_IDLE) ? int'(data_in) : int'(addr);
    if (s != M_IDLE && dest < 3 && srst[dest]) return M_IDLE;
    case (s)
      M_IDLE:   if (pkt_valid && dest != 3) return emp[dest] ? M_HDR : M_WAIT;
      M_WAIT:   return emp[dest] ? M_HDR : M_WAIT;
      M_HDR:    return M_BODY;
      M_BODY:   return fifo_full ? M_STALL : (pkt_valid ? M_BODY : M_PAR);
      M_STALL:  return fifo_full ? M_STALL : M_RESUME;
      M_RESUME: return parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_BODY);
      M_PAR:    return M_CHK;
      M_CHK:    return fifo_full ? M_STALL : M_IDLE;
      default:  return M_IDLE;
    endcase
    return M_IDLE;
  endfunction
  task automatic do_reset();
    drive(0, 0, 0, 3'b111, 0, 0, 0);
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    ms = M_IDLE;
    maddr = 0;
  endtask
  initial begin
    add("p1_hdr", 1, 1, 0, 3'b111, 0, 0, 0, O_LFD);
    add("p1_ld1", 1, 1, 0, 3'b111, 0, 0, 0, O_LD);
    add("p1_ld2", 1, 0, 0, 3'b111, 0, 0, 0, O_LD);
    add("p1_ld3", 1, 2, 0, 3'b111, 0, 0, 0, O_LD);
    add("p1_ld4", 1, 3, 0, 3'b111, 0, 0, 0, O_LD);
    add("p1_lp", 0, 0, 0, 3'b111, 0, 0, 0, O_LP);
    add("p1_cpe", 0, 0, 0, 3'b111, 0, 0, 0, O_CPE);
    add("p1_done", 0, 0, 0, 3'b111, 0, 0, 0, O_DA);
    add("f_hdr", 1, 0, 0, 3'b111, 0, 0, 0, O_LFD);
    add("f_ld", 1, 0, 0, 3'b111, 0, 0, 0, O_LD);
    add("f_full1", 1, 0, 1, 3'b111, 0, 0, 0, O_FF);
    add("f_full2", 1, 0, 1, 3'b111, 0, 0, 0, O_FF);
    add("f_full3", 1, 0, 1, 3'b111, 0, 0, 0, O_FF);
    add("f_laf", 1, 0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("f_laf_ld", 1, 0, 0, 3'b111, 0, 0, 0, O_LD);
    add("f_full_wins", 0, 0, 1, 3'b111, 0, 0, 0, O_FF);
    add("f_laf2", 0, 0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("f_laf_lp", 0, 0, 0, 3'b111, 0, 0, 1, O_LP);
    add("f_lp_cpe", 0, 0, 1, 3'b111, 0, 0, 1, O_CPE);
    add("f_cpe_ff", 0, 0, 1, 3'b111, 0, 0, 0, O_FF);
    add("f_laf3", 0, 0, 0, 3'b111, 0, 0, 0, O_LAF);
    add("f_laf_pd", 0, 0, 0, 3'b111, 0, 1, 1, O_DA);
    add("s_hdr", 1, 0, 0, 3'b111, 0, 0, 0, O_LFD);
    add("s_ld", 1, 0, 0, 3'b111, 0, 0, 0, O_LD);
    add("s_other", 1, 0, 0, 3'b111, 3'b110, 0, 0, O_LD);
    add("s_own", 1, 0, 0, 3'b111, 3'b001, 0, 0, O_DA);
    add("inv_hdr", 1, 3, 0, 3'b111, 0, 0, 0, O_DA);
    add("inv_hold", 1, 3, 0, 3'b000, 0, 0, 0, O_DA);
    add("w_hdr", 1, 2, 0, 3'b011, 0, 0, 0, O_WTE);
    add("w_din1", 1, 1, 0, 3'b011, 0, 0, 0, O_WTE);
    add("w_din0", 1, 0, 0, 3'b011, 0, 0, 0, O_WTE);
    add("w_go", 1, 0, 0, 3'b100, 0, 0, 0, O_LFD);
    add("w_ld", 1, 0, 0, 3'b111, 3'b011, 0, 0, O_LD);
    add("w_srst2", 1, 0, 0, 3'b111, 3'b100, 0, 0, O_DA);
    add("da_srst", 0, 0, 0, 3'b111, 3'b111, 0, 0, O_DA);
    do_reset();
    chk("reset", outs, O_DA);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_hold", outs, O_DA);
    end
    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].emp, vecs[i].srst, vecs[i].pd, vecs[i].lpv);
      tick();
      chk(vecs[i].name, outs, vecs[i].exp);
    end
    drive(1, 2, 0, 3'b011, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("wait7", outs, O_WTE);
      data_in = 2'($urandom_range(0, 3));
    end
    emp = 3'b111;
    tick();
    chk("wait7_lfd", outs, O_LFD);
    tick();
    chk("wait7_ld", outs, O_LD);
    #2 resetn = 0;
    #1 chk("async_rst", outs, O_DA);
    #2 resetn = 1;
    drive(0, 0, 0, 3'b111, 0, 0, 0);
    tick();
    chk("no_resume", outs, O_DA);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      mst_t nx;
      drive($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 3'b111 : 3'b000),
            $urandom_range(0, 19) == 0 ? 3'($urandom_range(1, 7)) : 3'b000,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      nx = model_next(ms, maddr);
      if (ms == M_IDLE && pkt_valid && data_in != 2'b11) maddr = data_in;
      ms = nx;
      tick();
      chk("random", outs, model_out(ms));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
